axi4_mem_master: RTL and testbench
==================================

AXI4_MEM_MASTER -- requirements
Module: axi4_mem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the mem and AXI address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 1: id width, carried mem id -> AXI id -> mem id.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port mem_request, std_mem_intf slave, -: incoming requests (valid, ready, read_enable, write_enable, addr, data, id).
REQ-007 SHALL have port mem_response, std_mem_intf master, -: outgoing responses.
REQ-008 SHALL have ports axi_ar, axi_aw, axi_w, axi4 master, -: AXI4 address and write channels driven by this block.
REQ-009 SHALL have ports axi_r, axi_b, axi4 master, -: AXI4 read-data and write-response channels consumed by this block.
REQ-010 SHALL have port error, output, 1: sticky bus-error flag (see Configuration).

Function
REQ-011 SHALL use FSM states IDLE, READ_ADDR, READ_DATA, WRITE, WRITE_RESP, RESPOND.
REQ-012 SHALL assert mem_request.ready only in IDLE, so at most one transaction is outstanding.
REQ-013 SHALL register addr, data, write_enable and id on a request handshake in IDLE.
REQ-014 SHALL decode each request as follows: write_enable != 0 -> WRITE (write wins if read_enable is also set); else read_enable=1 -> READ_ADDR; else the request is dropped, no response is produced, and the FSM stays in IDLE.
REQ-015 SHALL drive every AR/AW beat single-beat: len=0, size=log2(DATA_WIDTH/8), burst=INCR, lock=NORMAL, cache=0, prot=0, qos=0, region=0, user=0, addr unchanged, id=request id.
REQ-016 SHALL assert arvalid in READ_ADDR from a register, hold it with all fields stable until arready, then go to READ_DATA.
REQ-017 SHALL assert rready in READ_DATA and, on the r handshake, capture rdata into the response as read_enable=1, write_enable=0, with addr and id taken from the request, then go to RESPOND.
REQ-018 SHALL, in WRITE, assert awvalid and wvalid together, with wdata=data, wstrb=write_enable, wlast=1.
REQ-019 SHALL drop awvalid and wvalid independently after their own handshakes, in the same or different cycles.
REQ-020 SHALL go to WRITE_RESP only after both the aw and w handshakes are done.
REQ-021 SHALL assert bready in WRITE_RESP and, on the b handshake, form the response as read_enable=0, write_enable=request strobe, data=0, with addr and id taken from the request, then go to RESPOND.
REQ-022 SHALL hold mem_response.valid with all fields stable in RESPOND until mem_response.ready, then return to IDLE.
REQ-023 SHALL have a minimum read latency of 3 cycles from the request handshake to mem_response.valid when all ready/valid inputs are 1.
REQ-024 SHALL have a minimum write latency of 3 cycles from the request handshake to mem_response.valid when all ready/valid inputs are 1.
REQ-025 SHALL pass returned rid and bid through unchecked; only the registered request id is used for the response.

Reset
REQ-026 SHALL, while rst is low, set FSM=IDLE and arvalid, awvalid, wvalid, rready, bready, mem_response.valid, mem_request.ready and error to 0, independent of clk.
REQ-027 SHALL, on a mid-transaction reset, abandon the AXI transaction with no response and accept a new request in the first cycle after rst rises.

Configuration
REQ-028 SHALL, with AXI4_MEM_MASTER_ERROR_EN defined, set error on any rresp or bresp other than OKAY, or on a read beat with rlast=0, and hold error until reset.
REQ-029 SHALL, with AXI4_MEM_MASTER_ERROR_EN undefined, tie error to 0 and ignore rresp, bresp and rlast; all other behaviour is identical.

Structure
REQ-030 SHALL take burst, lock, cache, prot and resp types from the existing axi4 package, and SHALL add a shared size-from-data-width function to that package.
REQ-031 SHALL keep the FSM state enum local to the module and have no sub-modules.

Verification
REQ-032 SHALL cover a read: request re=1, addr=0x400, id=1; AR/R ready immediately, rdata=0x800 -> araddr=0x400, arlen=0, arsize=2, then response data=0x800, id=1, read_enable=1 exactly 3 cycles after the request.
REQ-033 SHALL cover a split write: request we=0xF, addr=0x50000400, data=0x42; awready 2 cycles later than wready -> one AW, one W (wstrb=0xF, wlast=1), response write_enable=0xF after bvalid.
REQ-034 SHALL cover backpressure: mem_response.ready=0 for 5 cycles -> response held stable and mem_request.ready=0 throughout.
REQ-035 SHALL cover a no-op: request re=0, we=0 -> no AXI activity, no response, ready stays 1.
REQ-036 SHALL cover an error (macro defined): bresp=SLVERR -> error=1, still 1 after the next OKAY read.
REQ-037 SHALL cover reset mid-transaction: rst low while in READ_DATA -> all valids 0 immediately, a new request accepted after release.

Source files
------------

// File: rtl/axi4_mem_master_pkg.sv
// AXI4 channel encodings shared by AXI masters, and the AxSIZE helper derived from a data width.
package axi4_mem_master_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi4_burst_t;

    typedef enum logic {
        AXI_LOCK_NORMAL    = 1'b0,
        AXI_LOCK_EXCLUSIVE = 1'b1
    } axi4_lock_t;

    typedef logic [3:0] axi4_cache_t;
    typedef logic [2:0] axi4_prot_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi4_resp_t;

    // AxSIZE is log2 of the bytes per beat; only power-of-two widths from 8 to 1024 bits are legal.
    function automatic logic [2:0] axi4_size_from_width(input int unsigned data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi4_mem_master.sv
// Bridges a simple valid/ready memory request port onto single-beat AXI4, one transaction at a time.
// Optional sticky bus-error reporting is enabled with `define AXI4_MEM_MASTER_ERROR_EN.
module axi4_mem_master
    import axi4_mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    mem_request_valid,
    output logic                    mem_request_ready,
    input  logic                    mem_request_read_enable,
    input  logic [DATA_WIDTH/8-1:0] mem_request_write_enable,
    input  logic [ADDR_WIDTH-1:0]   mem_request_addr,
    input  logic [DATA_WIDTH-1:0]   mem_request_data,
    input  logic [ID_WIDTH-1:0]     mem_request_id,

    output logic                    mem_response_valid,
    input  logic                    mem_response_ready,
    output logic                    mem_response_read_enable,
    output logic [DATA_WIDTH/8-1:0] mem_response_write_enable,
    output logic [ADDR_WIDTH-1:0]   mem_response_addr,
    output logic [DATA_WIDTH-1:0]   mem_response_data,
    output logic [ID_WIDTH-1:0]     mem_response_id,

    output logic                    axi_ar_valid,
    input  logic                    axi_ar_ready,
    output logic [ADDR_WIDTH-1:0]   axi_ar_addr,
    output logic [ID_WIDTH-1:0]     axi_ar_id,
    output logic [7:0]              axi_ar_len,
    output logic [2:0]              axi_ar_size,
    output logic [1:0]              axi_ar_burst,
    output logic                    axi_ar_lock,
    output logic [3:0]              axi_ar_cache,
    output logic [2:0]              axi_ar_prot,
    output logic [3:0]              axi_ar_qos,
    output logic [3:0]              axi_ar_region,
    output logic [0:0]              axi_ar_user,

    output logic                    axi_aw_valid,
    input  logic                    axi_aw_ready,
    output logic [ADDR_WIDTH-1:0]   axi_aw_addr,
    output logic [ID_WIDTH-1:0]     axi_aw_id,
    output logic [7:0]              axi_aw_len,
    output logic [2:0]              axi_aw_size,
    output logic [1:0]              axi_aw_burst,
    output logic                    axi_aw_lock,
    output logic [3:0]              axi_aw_cache,
    output logic [2:0]              axi_aw_prot,
    output logic [3:0]              axi_aw_qos,
    output logic [3:0]              axi_aw_region,
    output logic [0:0]              axi_aw_user,

    output logic                    axi_w_valid,
    input  logic                    axi_w_ready,
    output logic [DATA_WIDTH-1:0]   axi_w_data,
    output logic [DATA_WIDTH/8-1:0] axi_w_strb,
    output logic                    axi_w_last,

    input  logic                    axi_r_valid,
    output logic                    axi_r_ready,
    input  logic [DATA_WIDTH-1:0]   axi_r_data,
    input  logic [ID_WIDTH-1:0]     axi_r_id,
    input  logic [1:0]              axi_r_resp,
    input  logic                    axi_r_last,

    input  logic                    axi_b_valid,
    output logic                    axi_b_ready,
    input  logic [ID_WIDTH-1:0]     axi_b_id,
    input  logic [1:0]              axi_b_resp,

    output logic                    error
);

    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = axi4_size_from_width(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        READ_ADDR,
        READ_DATA,
        WRITE,
        WRITE_RESP,
        RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_W-1:0]       we_q, we_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_re_q, resp_re_d;
    logic [STRB_W-1:0]       resp_we_q, resp_we_d;
    logic                    req_hs;

    assign req_hs = mem_request_valid && mem_request_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    if (|mem_request_write_enable)    state_d = WRITE;
                    else if (mem_request_read_enable) state_d = READ_ADDR;
                end
            end
            READ_ADDR:  if (axi_ar_ready)       state_d = READ_DATA;
            READ_DATA:  if (axi_r_valid)        state_d = RESPOND;
            WRITE:      if (aw_done_d && w_done_d) state_d = WRITE_RESP;
            WRITE_RESP: if (axi_b_valid)        state_d = RESPOND;
            RESPOND:    if (mem_response_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // AW and W complete independently; the done flags remember which half already handshook.
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = we_q;
        id_d        = id_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        resp_data_d = resp_data_q;
        resp_re_d   = resp_re_q;
        resp_we_d   = resp_we_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    addr_d    = mem_request_addr;
                    data_d    = mem_request_data;
                    we_d      = mem_request_write_enable;
                    id_d      = mem_request_id;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            READ_DATA: begin
                if (axi_r_valid) begin
                    resp_data_d = axi_r_data;
                    resp_re_d   = 1'b1;
                    resp_we_d   = '0;
                end
            end
            WRITE: begin
                aw_done_d = aw_done_q || axi_aw_ready;
                w_done_d  = w_done_q || axi_w_ready;
            end
            WRITE_RESP: begin
                if (axi_b_valid) begin
                    resp_data_d = '0;
                    resp_re_d   = 1'b0;
                    resp_we_d   = we_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= '0;
            id_q        <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_data_q <= '0;
            resp_re_q   <= 1'b0;
            resp_we_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            id_q        <= id_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            resp_data_q <= resp_data_d;
            resp_re_q   <= resp_re_d;
            resp_we_q   <= resp_we_d;
        end
    end

    // Request ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        mem_request_ready  = rst && (state_q == IDLE);
        axi_ar_valid       = (state_q == READ_ADDR);
        axi_aw_valid       = (state_q == WRITE) && !aw_done_q;
        axi_w_valid        = (state_q == WRITE) && !w_done_q;
        axi_r_ready        = (state_q == READ_DATA);
        axi_b_ready        = (state_q == WRITE_RESP);
        mem_response_valid = (state_q == RESPOND);
    end

    assign mem_response_read_enable  = resp_re_q;
    assign mem_response_write_enable = resp_we_q;
    assign mem_response_addr         = addr_q;
    assign mem_response_data         = resp_data_q;
    assign mem_response_id           = id_q;

    assign axi_ar_addr   = addr_q;
    assign axi_ar_id     = id_q;
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = AXSIZE;
    assign axi_ar_burst  = AXI_BURST_INCR;
    assign axi_ar_lock   = AXI_LOCK_NORMAL;
    assign axi_ar_cache  = '0;
    assign axi_ar_prot   = '0;
    assign axi_ar_qos    = '0;
    assign axi_ar_region = '0;
    assign axi_ar_user   = '0;

    assign axi_aw_addr   = addr_q;
    assign axi_aw_id     = id_q;
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = AXSIZE;
    assign axi_aw_burst  = AXI_BURST_INCR;
    assign axi_aw_lock   = AXI_LOCK_NORMAL;
    assign axi_aw_cache  = '0;
    assign axi_aw_prot   = '0;
    assign axi_aw_qos    = '0;
    assign axi_aw_region = '0;
    assign axi_aw_user   = '0;

    assign axi_w_data    = data_q;
    assign axi_w_strb    = we_q;
    assign axi_w_last    = 1'b1;

`ifdef AXI4_MEM_MASTER_ERROR_EN
    logic error_q, error_d;
    logic unused_ids;

    assign unused_ids = ^{axi_r_id, axi_b_id};

    always_comb begin
        error_d = error_q;
        if ((state_q == READ_DATA) && axi_r_valid &&
            ((axi_r_resp != AXI_RESP_OKAY) || !axi_r_last)) error_d = 1'b1;
        if ((state_q == WRITE_RESP) && axi_b_valid &&
            (axi_b_resp != AXI_RESP_OKAY)) error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) error_q <= 1'b0;
        else      error_q <= error_d;
    end

    assign error = error_q;
`else
    logic unused_status;

    assign unused_status = ^{axi_r_id, axi_b_id, axi_r_resp, axi_r_last, axi_b_resp};
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_mem_master.sv
// Directed bench for axi4_mem_master: read, split write, backpressure, no-op, bus error and mid-transaction reset.
module tb_axi4_mem_master;

`ifdef AXI4_MEM_MASTER_ERROR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_re;
    logic [3:0]  req_we;
    logic [31:0] req_addr, req_data;
    logic [0:0]  req_id;
    logic        resp_valid, resp_ready, resp_re;
    logic [3:0]  resp_we;
    logic [31:0] resp_addr, resp_data;
    logic [0:0]  resp_id;
    logic        ar_valid, ar_ready, ar_lock, aw_valid, aw_ready, aw_lock;
    logic [31:0] ar_addr, aw_addr;
    logic [0:0]  ar_id, aw_id, ar_user, aw_user;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size, ar_prot, aw_prot;
    logic [1:0]  ar_burst, aw_burst;
    logic [3:0]  ar_cache, aw_cache, ar_qos, aw_qos, ar_region, aw_region;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [0:0]  r_id, b_id;
    logic [1:0]  r_resp, b_resp;
    logic        b_valid, b_ready;
    logic        error;

    int total = 0;
    int bad   = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    axi4_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .mem_request_valid(req_valid), .mem_request_ready(req_ready),
        .mem_request_read_enable(req_re), .mem_request_write_enable(req_we),
        .mem_request_addr(req_addr), .mem_request_data(req_data), .mem_request_id(req_id),
        .mem_response_valid(resp_valid), .mem_response_ready(resp_ready),
        .mem_response_read_enable(resp_re), .mem_response_write_enable(resp_we),
        .mem_response_addr(resp_addr), .mem_response_data(resp_data), .mem_response_id(resp_id),
        .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_addr(ar_addr), .axi_ar_id(ar_id),
        .axi_ar_len(ar_len), .axi_ar_size(ar_size), .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock),
        .axi_ar_cache(ar_cache), .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos),
        .axi_ar_region(ar_region), .axi_ar_user(ar_user),
        .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_addr(aw_addr), .axi_aw_id(aw_id),
        .axi_aw_len(aw_len), .axi_aw_size(aw_size), .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock),
        .axi_aw_cache(aw_cache), .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos),
        .axi_aw_region(aw_region), .axi_aw_user(aw_user),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_data(w_data),
        .axi_w_strb(w_strb), .axi_w_last(w_last),
        .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_data(r_data),
        .axi_r_id(r_id), .axi_r_resp(r_resp), .axi_r_last(r_last),
        .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_id(b_id), .axi_b_resp(b_resp),
        .error(error)
    );

    always @(posedge clk) begin
        if (ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;
        if (aw_valid && aw_ready) aw_cnt <= aw_cnt + 1;
        if (w_valid && w_ready)   w_cnt  <= w_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic re, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [0:0] id);
        req_valid = 1'b1; req_re = re; req_we = we;
        req_addr = addr; req_data = data; req_id = id;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 0; req_re = 0; req_we = 0; req_addr = 0; req_data = 0; req_id = 0;
        resp_ready = 0; ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; r_data = 0; r_id = 0; r_resp = 0; r_last = 1;
        b_valid = 0; b_id = 0; b_resp = 0;

        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, resp_valid}, 0);
        chk("rst_error", error, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        #1 chk("rel_req_ready", req_ready, 1);

        // read: AR/R ready immediately, response exactly 3 cycles after the handshake
        ar_ready = 1; r_valid = 1; r_data = 32'h800; r_id = 0; r_resp = 0; r_last = 1; resp_ready = 1;
        send(1'b1, 4'h0, 32'h400, 32'h0, 1'b1);
        tick; req_valid = 0;
        chk("rd_arvalid", ar_valid, 1);
        chk("rd_araddr", ar_addr, 32'h400);
        chk("rd_arlen_size_burst", {ar_len, ar_size, ar_burst}, {8'd0, 3'd2, 2'd1});
        chk("rd_ar_misc", {ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user}, 0);
        chk("rd_arid", ar_id, 1);
        chk("rd_c1_resp", resp_valid, 0);
        chk("rd_c1_ready", req_ready, 0);
        tick;
        chk("rd_rready", r_ready, 1);
        chk("rd_c2_arvalid", ar_valid, 0);
        chk("rd_c2_resp", resp_valid, 0);
        tick;
        chk("rd_c3_resp", resp_valid, 1);
        chk("rd_data", resp_data, 32'h800);
        chk("rd_id", resp_id, 1);
        chk("rd_re_we", {resp_re, resp_we}, 5'b1_0000);
        chk("rd_addr", resp_addr, 32'h400);
        tick;
        chk("rd_done_resp", resp_valid, 0);
        chk("rd_done_ready", req_ready, 1);
        chk("rd_ar_count", ar_cnt, 1);
        ar_ready = 0; r_valid = 0;

        // split write: W accepted first, AW two cycles later, then B; response held by backpressure
        aw_ready = 0; w_ready = 1; b_valid = 0; resp_ready = 0;
        send(1'b0, 4'hF, 32'h5000_0400, 32'h42, 1'b0);
        tick; req_valid = 0; req_we = 0;
        chk("wr_awvalid", aw_valid, 1);
        chk("wr_wvalid", w_valid, 1);
        chk("wr_awaddr", aw_addr, 32'h5000_0400);
        chk("wr_awlen_size_burst", {aw_len, aw_size, aw_burst}, {8'd0, 3'd2, 2'd1});
        chk("wr_aw_misc", {aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_id}, 0);
        chk("wr_w_beat", {w_data, w_strb, w_last}, {32'h42, 4'hF, 1'b1});
        tick;
        chk("wr_c2_wvalid", w_valid, 0);
        chk("wr_c2_awvalid", aw_valid, 1);
        tick;
        chk("wr_c3_awvalid", aw_valid, 1);
        chk("wr_c3_bready", b_ready, 0);
        aw_ready = 1;
        tick;
        chk("wr_c4_awvalid", aw_valid, 0);
        chk("wr_c4_bready", b_ready, 1);
        chk("wr_c4_resp", resp_valid, 0);
        b_valid = 1; b_resp = 0; b_id = 1;
        tick; b_valid = 0;
        chk("wr_resp_valid", resp_valid, 1);
        chk("wr_resp_fields", {resp_re, resp_we, resp_data}, {1'b0, 4'hF, 32'h0});
        chk("wr_resp_addr", resp_addr, 32'h5000_0400);
        chk("wr_resp_id", resp_id, 0);
        chk("wr_aw_count", aw_cnt, 1);
        chk("wr_w_count", w_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_valid", resp_valid, 1);
            chk("bp_fields", {resp_we, resp_addr, resp_data}, {4'hF, 32'h5000_0400, 32'h0});
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1;
        tick;
        chk("bp_release_resp", resp_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // no-op request: accepted and dropped, no AXI traffic, no response
        snap = ar_cnt + aw_cnt + w_cnt;
        send(1'b0, 4'h0, 32'h99, 32'h1, 1'b1);
        tick; req_valid = 0;
        chk("noop_ready", req_ready, 1);
        chk("noop_valids", {ar_valid, aw_valid, w_valid}, 0);
        tick; tick;
        chk("noop_resp", resp_valid, 0);
        chk("noop_axi", ar_cnt + aw_cnt + w_cnt, snap);

        // write wins over read; SLVERR on B sets the sticky error
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b10; b_id = 0;
        send(1'b1, 4'h3, 32'h10, 32'h1234, 1'b1);
        tick; req_valid = 0; req_re = 0; req_we = 0;
        chk("err_wr_wins", {aw_valid, ar_valid}, 2'b10);
        chk("err_wstrb", w_strb, 4'h3);
        tick;
        chk("err_bready", b_ready, 1);
        chk("err_aw_w_done", {aw_valid, w_valid}, 0);
        tick;
        chk("err_resp", {resp_valid, resp_we, resp_id}, {1'b1, 4'h3, 1'b1});
        chk("err_flag", error, ERR_EXP);
        b_valid = 0; b_resp = 0;
        tick;
        chk("err_idle_flag", error, ERR_EXP);
        ar_ready = 1; r_valid = 1; r_data = 32'h55; r_resp = 0; r_last = 1; r_id = 1;
        send(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
        tick; req_valid = 0; req_re = 0;
        tick; tick;
        chk("ok_rd_resp", {resp_valid, resp_data}, {1'b1, 32'h55});
        chk("ok_rd_id", resp_id, 0);
        chk("err_sticky", error, ERR_EXP);
        tick;
        r_valid = 0;

        // reset in READ_DATA: outputs drop at once, new request accepted right after release
        ar_ready = 1;
        send(1'b1, 4'h0, 32'h30, 32'h0, 1'b1);
        tick; req_valid = 0; req_re = 0;
        tick;
        chk("mid_rready", r_ready, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, resp_valid}, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_error", error, 0);
        tick;
        rst = 1'b1;
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 0; resp_ready = 1;
        send(1'b0, 4'h1, 32'h60, 32'h7, 1'b0);
        #1 chk("post_rst_ready", req_ready, 1);
        tick; req_valid = 0; req_we = 0;
        chk("post_rst_accept", aw_valid, 1);
        tick; tick;
        chk("post_rst_resp", {resp_valid, resp_we, resp_addr}, {1'b1, 4'h1, 32'h60});
        chk("post_rst_error", error, 0);
        b_valid = 0;
        tick;
        chk("post_rst_idle", {req_ready, resp_valid}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
